bus_arbiter_param: RTL and testbench
====================================

Name: bus_arbiter_param

Overview:
- Parametrised successor to the fixed 12-master bus controller on the serial shared bus.
- Arbitrates NUM_MASTERS request lines onto one bus.
  - Mode is selectable at runtime: fixed-priority or round-robin.
  - A grant-acceptance watchdog revokes stale grants.
  - Split transactions: a busy slave parks its master, and the arbiter re-grants that master when the slave becomes ready.
- Sits between the masters/interfaces and the slaves, alongside the open-drain bus_util line.

Parameters:
- NUM_MASTERS, 12, number of request/grant pairs (2..16).
- NUM_SLAVES, 6, number of split-capable slaves (1..8).
- MID_W, 4, width of mid_current; must be >= clog2(NUM_MASTERS).
- GRANT_TIMEOUT, 64, cycles a granted master may take to pull bus_util low before the grant is revoked (>= 2).

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset. Synchronous, active-low; sampled on rising clk edge.
- arb_mode  in  1  0 = fixed priority (lowest index wins), 1 = round-robin. Sampled only in IDLE.
- m_reqs  in  NUM_MASTERS  level request per master.
- m_grants  out  NUM_MASTERS  one-hot or zero grant, registered.
- bus_util  in  1  bus utilisation, active-low (pulled up; master drives 0 while using the bus).
- slaves_in  in  NUM_SLAVES  slave busy/split flag, high = slave cannot complete now.
- slaves_out  out  NUM_SLAVES  resume strobe-level to slave i, high while its parked master is re-granted.
- mid_current  out  MID_W  index of the master last granted.
- state  out  4  encoded FSM state for 7-seg debug.
- timeout_evt  out  1  one-cycle pulse when a grant is revoked by the watchdog.

Behaviour:
- Reset (rstn=0 at a clk edge), applied next edge from any state, mid-transaction included:
  - m_grants=0, slaves_out=0, mid_current=0, timeout_evt=0, state=IDLE(0).
  - RR pointer=0.
  - All split records cleared.
- FSM encoding: IDLE=0, GRANT=1, BUSY=2, RELEASE=3. Other codes unused and recover to IDLE.
- Eligible set = m_reqs with parked masters masked out (a master is parked if any split_valid[i] has owner == that master).
- IDLE:
  - Resume has priority over normal requests.
    - If any resume_pend[i] exists, take the lowest i.
    - Grant split_owner[i] (its request line is not required), set slaves_out[i]=1, go to GRANT.
  - Otherwise, if the eligible set is non-empty, choose the winner and go to GRANT.
    - Fixed mode: lowest index wins.
    - RR mode: first set bit at or above the RR pointer, wrapping modulo NUM_MASTERS.
  - On either path, m_grants and mid_current update on the same edge.
  - Latency: request visible at edge N gives the grant at edge N+1.
- GRANT:
  - Watchdog counter starts at 0 and increments each cycle.
  - bus_util==0 -> BUSY. The grant is held.
  - Non-resume grant and the granted m_reqs bit dropped (with bus_util still 1) -> RELEASE, no timeout_evt.
  - Counter reaches GRANT_TIMEOUT-1 with bus_util still 1:
    - Drop the grant and pulse timeout_evt.
    - If this was a resume grant, keep the split record pending.
    - Go to RELEASE.
- BUSY:
  - If slaves_in[i] rises (0->1 vs previous cycle) and no split_valid[i] exists: split_owner[i]=mid_current, split_valid[i]=1.
  - bus_util returns to 1 -> RELEASE. m_grants clears on this same edge.
- RELEASE:
  - One cycle; m_grants=0 and slaves_out=0.
  - RR pointer = (mid_current+1) mod NUM_MASTERS.
  - If a resume grant completed normally, clear split_valid[i] and resume_pend[i].
  - Go to IDLE. There is a minimum 1-cycle bus gap between owners.
- resume_pend[i] is set when split_valid[i] is set and slaves_in[i] falls. Checked in every state.
- Simultaneous events:
  - Rise and fall of the same slave flag cannot occur in one cycle.
  - A fall in the same cycle as the split record is created sets resume_pend on the next edge.
- m_grants is never multi-hot. mid_current holds its value in IDLE.
- Requests from NUM_MASTERS bits only; no out-of-range index is ever produced.

Decomposition:
- Shared package bus_pkg holds:
  - FSM state constants (IDLE/GRANT/BUSY/RELEASE).
  - The arbitration mode constants.
  - A default MID_W of 4, shared with the masters' display logic.
- One natural sub-module: rr_priority_pick.
  - Combinational: request vector, pointer and mode in; one-hot winner and index out.
  - Reused by future slave-side arbiters.

Test Plan:
- Fixed mode, m_reqs=0x028 held -> grant 0x008 one cycle later, mid_current=3. The master pulls bus_util low 2 cycles, then releases -> one RELEASE cycle, then grant 0x020.
- RR mode, masters 1, 3 and 5 all request continuously, each using the bus for 4 cycles -> grant order 1,3,5,1,3,5. The pointer wraps past NUM_MASTERS-1 to 0.
- Granted master 4 never drives bus_util -> grant dropped after exactly GRANT_TIMEOUT (64) cycles in GRANT, timeout_evt high for 1 cycle, state 3 then 0.
- Master 2 in BUSY while slaves_in[3] rises, then the bus is released:
  - Master 2's request is masked while master 5 is served.
  - slaves_in[3] falls -> master 2 granted ahead of pending master 1, slaves_out[3]=1 until its RELEASE.
- rstn=0 for 1 cycle while in BUSY with a split record live -> next edge grants=0, state=0, slaves_out=0, mid_current=0. The split record is gone, so master 2 is eligible again.
- arb_mode toggled during BUSY -> the current owner is unaffected; the new mode applies at the next IDLE decision.

Source files
------------

// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Shared constants for the shared-bus arbiter family: FSM state codes (also
// shown on the 7-segment debug display), arbitration mode codes, and the
// default master-index width used by the masters' display logic.
// -----------------------------------------------------------------------------
package bus_pkg;

    localparam int DEFAULT_MID_W = 4;

    localparam logic MODE_FIXED = 1'b0;  // lowest index wins
    localparam logic MODE_RR    = 1'b1;  // rotate from the pointer

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_GRANT   = 4'd1,
        ST_BUSY    = 4'd2,
        ST_RELEASE = 4'd3
    } arb_state_e;

endpackage

// File: rtl/rr_priority_pick.sv
// -----------------------------------------------------------------------------
// rr_priority_pick
// Combinational winner selection over a request vector.
//   req      in   N      request bits
//   ptr      in   IDX_W  round-robin start index (must be < N)
//   mode     in   1      MODE_FIXED: lowest index; MODE_RR: first at/above ptr
//   win_oh   out  N      one-hot winner (zero when no request)
//   win_idx  out  IDX_W  winner index (0 when no request)
//   win_any  out  1      at least one request present
// -----------------------------------------------------------------------------
module rr_priority_pick
    import bus_pkg::*;
#(
    parameter int N     = 12,
    parameter int IDX_W = 4
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             mode,
    output logic [N-1:0]     win_oh,
    output logic [IDX_W-1:0] win_idx,
    output logic             win_any
);

    int best_d;
    int d;

    // Each requester gets a distance from the scan start; the smallest wins.
    // In fixed mode the start is 0, so distance is just the index.
    always_comb begin
        best_d  = N;
        d       = 0;
        win_idx = '0;
        win_any = 1'b0;
        for (int j = 0; j < N; j++) begin
            d = (mode == MODE_RR) ? j - int'(ptr) : j;
            if (d < 0) d = d + N;
            if (req[j] && d < best_d) begin
                best_d  = d;
                win_idx = IDX_W'(j);
                win_any = 1'b1;
            end
        end
    end

    always_comb begin
        win_oh = '0;
        for (int j = 0; j < N; j++)
            win_oh[j] = win_any && (win_idx == IDX_W'(j));
    end

endmodule

// File: rtl/bus_arbiter_param.sv
// -----------------------------------------------------------------------------
// bus_arbiter_param
// Arbitrates NUM_MASTERS level requests onto one shared bus, with runtime
// fixed/round-robin mode, a grant-acceptance watchdog and split-transaction
// parking/resume for NUM_SLAVES slaves.
//   clk          in   1            system clock
//   rstn         in   1            synchronous active-low reset
//   arb_mode     in   1            0 fixed priority, 1 round-robin (IDLE only)
//   m_reqs       in   NUM_MASTERS  level request per master
//   m_grants     out  NUM_MASTERS  registered one-hot/zero grant
//   bus_util     in   1            active-low bus-in-use line
//   slaves_in    in   NUM_SLAVES   slave busy/split flag
//   slaves_out   out  NUM_SLAVES   high while slave's parked master is re-granted
//   mid_current  out  MID_W        index of master last granted
//   state        out  4            FSM state code for debug display
//   timeout_evt  out  1            one-cycle pulse on watchdog revoke
// -----------------------------------------------------------------------------
module bus_arbiter_param
    import bus_pkg::*;
#(
    parameter int NUM_MASTERS   = 12,
    parameter int NUM_SLAVES    = 6,
    parameter int MID_W         = DEFAULT_MID_W,
    parameter int GRANT_TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   arb_mode,
    input  logic [NUM_MASTERS-1:0] m_reqs,
    output logic [NUM_MASTERS-1:0] m_grants,
    input  logic                   bus_util,
    input  logic [NUM_SLAVES-1:0]  slaves_in,
    output logic [NUM_SLAVES-1:0]  slaves_out,
    output logic [MID_W-1:0]       mid_current,
    output logic [3:0]             state,
    output logic                   timeout_evt
);

    localparam int SLV_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int WD_W  = $clog2(GRANT_TIMEOUT);

    arb_state_e                       st;
    logic [MID_W-1:0]                 rr_ptr;
    logic [WD_W-1:0]                  wd_cnt;
    logic [NUM_SLAVES-1:0]            split_valid;
    logic [NUM_SLAVES-1:0]            resume_pend;
    logic [NUM_SLAVES-1:0]            slv_prev;
    logic [NUM_SLAVES-1:0][MID_W-1:0] split_owner;
    logic                             res_grant;      // current grant is a resume
    logic                             res_timed_out;  // ...and the watchdog fired
    logic [SLV_W-1:0]                 res_slot;

    logic [NUM_SLAVES-1:0]  slv_rise, slv_fall, res_sel_oh;
    logic [NUM_MASTERS-1:0] parked, eligible, pick_oh, res_oh;
    logic [MID_W-1:0]       pick_idx, res_owner, mid_next;
    logic                   pick_any, res_any, req_dropped;
    logic [SLV_W-1:0]       res_sel;

    assign slv_rise    = slaves_in & ~slv_prev;
    assign slv_fall    = ~slaves_in & slv_prev;
    assign eligible    = m_reqs & ~parked;
    assign state       = st;
    assign mid_next    = (mid_current == MID_W'(NUM_MASTERS - 1)) ? '0
                                                                   : mid_current + MID_W'(1);
    // Grant is registered one-hot, so masking requests with it tests the owner.
    assign req_dropped = ~|(m_reqs & m_grants);

    // Parked-master mask and lowest pending resume slot.
    always_comb begin
        parked    = '0;
        res_any   = 1'b0;
        res_sel   = '0;
        res_owner = '0;
        for (int s = NUM_SLAVES - 1; s >= 0; s--) begin
            for (int m = 0; m < NUM_MASTERS; m++)
                if (split_valid[s] && split_owner[s] == MID_W'(m)) parked[m] = 1'b1;
            // Descending scan: the last hit is the lowest pending slot.
            if (resume_pend[s]) begin
                res_any   = 1'b1;
                res_sel   = SLV_W'(s);
                res_owner = split_owner[s];
            end
        end
    end

    always_comb begin
        res_oh     = '0;
        res_sel_oh = '0;
        for (int m = 0; m < NUM_MASTERS; m++)
            res_oh[m] = (res_owner == MID_W'(m));
        for (int s = 0; s < NUM_SLAVES; s++)
            res_sel_oh[s] = (res_sel == SLV_W'(s));
    end

    rr_priority_pick #(
        .N     (NUM_MASTERS),
        .IDX_W (MID_W)
    ) u_pick (
        .req     (eligible),
        .ptr     (rr_ptr),
        .mode    (arb_mode),
        .win_oh  (pick_oh),
        .win_idx (pick_idx),
        .win_any (pick_any)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            st            <= ST_IDLE;
            m_grants      <= '0;
            slaves_out    <= '0;
            mid_current   <= '0;
            timeout_evt   <= 1'b0;
            rr_ptr        <= '0;
            wd_cnt        <= '0;
            split_valid   <= '0;
            split_owner   <= '0;
            resume_pend   <= '0;
            slv_prev      <= slaves_in;  // no spurious edge out of reset
            res_grant     <= 1'b0;
            res_timed_out <= 1'b0;
            res_slot      <= '0;
        end else begin
            timeout_evt <= 1'b0;
            slv_prev    <= slaves_in;
            // A parked master becomes resumable when its slave drops busy,
            // whatever the FSM is doing.
            resume_pend <= resume_pend | (split_valid & slv_fall);

            case (st)
                ST_IDLE: begin
                    if (res_any) begin
                        m_grants      <= res_oh;
                        mid_current   <= res_owner;
                        slaves_out    <= res_sel_oh;
                        res_grant     <= 1'b1;
                        res_timed_out <= 1'b0;
                        res_slot      <= res_sel;
                        wd_cnt        <= '0;
                        st            <= ST_GRANT;
                    end else if (pick_any) begin
                        m_grants      <= pick_oh;
                        mid_current   <= pick_idx;
                        res_grant     <= 1'b0;
                        res_timed_out <= 1'b0;
                        wd_cnt        <= '0;
                        st            <= ST_GRANT;
                    end
                end

                ST_GRANT: begin
                    if (!bus_util) begin
                        st <= ST_BUSY;
                    end else if (!res_grant && req_dropped) begin
                        m_grants   <= '0;
                        slaves_out <= '0;
                        st         <= ST_RELEASE;
                    end else if (wd_cnt == WD_W'(GRANT_TIMEOUT - 1)) begin
                        // Resume record stays pending so the master is retried.
                        m_grants      <= '0;
                        slaves_out    <= '0;
                        timeout_evt   <= 1'b1;
                        res_timed_out <= 1'b1;
                        st            <= ST_RELEASE;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end

                ST_BUSY: begin
                    for (int s = 0; s < NUM_SLAVES; s++) begin
                        if (slv_rise[s] && !split_valid[s]) begin
                            split_valid[s] <= 1'b1;
                            split_owner[s] <= mid_current;
                        end
                    end
                    if (bus_util) begin
                        m_grants   <= '0;
                        slaves_out <= '0;
                        st         <= ST_RELEASE;
                    end
                end

                ST_RELEASE: begin
                    rr_ptr <= mid_next;
                    if (res_grant && !res_timed_out) begin
                        for (int s = 0; s < NUM_SLAVES; s++) begin
                            if (res_slot == SLV_W'(s)) begin
                                split_valid[s] <= 1'b0;
                                resume_pend[s] <= 1'b0;
                            end
                        end
                    end
                    res_grant <= 1'b0;
                    st        <= ST_IDLE;
                end

                default: begin
                    m_grants   <= '0;
                    slaves_out <= '0;
                    st         <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter_param.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter_param
// Directed scenarios for bus_arbiter_param with an index-level reference model
// compared against every output on every cycle, plus literal expectations.
// -----------------------------------------------------------------------------
module tb_bus_arbiter_param;

    localparam int NM = 12;
    localparam int NS = 6;
    localparam int MW = 4;
    localparam int GT = 64;

    logic          clk = 1'b0;
    logic          rstn;
    logic          arb_mode;
    logic [NM-1:0] m_reqs;
    logic [NM-1:0] m_grants;
    logic          bus_util;
    logic [NS-1:0] slaves_in;
    logic [NS-1:0] slaves_out;
    logic [MW-1:0] mid_current;
    logic [3:0]    state;
    logic          timeout_evt;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    bus_arbiter_param #(
        .NUM_MASTERS   (NM),
        .NUM_SLAVES    (NS),
        .MID_W         (MW),
        .GRANT_TIMEOUT (GT)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .arb_mode    (arb_mode),
        .m_reqs      (m_reqs),
        .m_grants    (m_grants),
        .bus_util    (bus_util),
        .slaves_in   (slaves_in),
        .slaves_out  (slaves_out),
        .mid_current (mid_current),
        .state       (state),
        .timeout_evt (timeout_evt)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- reference model (master/slave indices, -1 = none) -----
    int  m_st, m_mid, m_ptr, m_wd, m_res;
    bit  m_to, m_fail, m_live;
    int  sp_own  [NS];
    bit  sp_pend [NS];
    bit  [NS-1:0] m_prev, pset;
    int  mj, ws, win, clr;

    function automatic bit parked(input int m);
        for (int s = 0; s < NS; s++) if (sp_own[s] == m) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        if (!rstn) begin
            m_st = 0; m_mid = 0; m_ptr = 0; m_wd = 0; m_res = -1;
            m_to = 1'b0; m_fail = 1'b0; m_live = 1'b1;
            for (int s = 0; s < NS; s++) begin sp_own[s] = -1; sp_pend[s] = 1'b0; end
            m_prev = slaves_in;
        end else begin
            m_to = 1'b0;
            clr  = -1;
            for (int s = 0; s < NS; s++)
                pset[s] = (sp_own[s] >= 0) && m_prev[s] && !slaves_in[s];
            case (m_st)
                0: begin
                    ws = -1;
                    for (int s = NS - 1; s >= 0; s--) if (sp_pend[s]) ws = s;
                    if (ws >= 0) begin
                        m_mid = sp_own[ws]; m_res = ws; m_fail = 1'b0; m_wd = 0; m_st = 1;
                    end else begin
                        win = -1;
                        for (int k = 0; k < NM; k++) begin
                            mj = arb_mode ? (m_ptr + k) % NM : k;
                            if (win < 0 && m_reqs[mj] && !parked(mj)) win = mj;
                        end
                        if (win >= 0) begin
                            m_mid = win; m_res = -1; m_fail = 1'b0; m_wd = 0; m_st = 1;
                        end
                    end
                end
                1: begin
                    if (!bus_util) m_st = 2;
                    else if (m_res < 0 && !m_reqs[m_mid]) m_st = 3;
                    else if (m_wd == GT - 1) begin m_st = 3; m_to = 1'b1; m_fail = 1'b1; end
                    else m_wd++;
                end
                2: begin
                    for (int s = 0; s < NS; s++)
                        if (!m_prev[s] && slaves_in[s] && sp_own[s] < 0) sp_own[s] = m_mid;
                    if (bus_util) m_st = 3;
                end
                default: begin
                    m_ptr = (m_mid + 1) % NM;
                    if (m_res >= 0 && !m_fail) begin
                        sp_own[m_res] = -1; sp_pend[m_res] = 1'b0; clr = m_res;
                    end
                    m_res = -1;
                    m_st  = 0;
                end
            endcase
            for (int s = 0; s < NS; s++) if (pset[s] && s != clr) sp_pend[s] = 1'b1;
            m_prev = slaves_in;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_live) begin
            chk("grants",   int'(m_grants),
                (m_st == 1 || m_st == 2) ? (1 << m_mid) : 0);
            chk("slv_out",  int'(slaves_out),
                ((m_st == 1 || m_st == 2) && m_res >= 0) ? (1 << m_res) : 0);
            chk("mid",      int'(mid_current), m_mid);
            chk("state",    int'(state), m_st);
            chk("timeout",  int'(timeout_evt), int'(m_to));
        end
    end

    // ---------------- stimulus helpers --------------------------------------
    task automatic wait_grant(output int idx);
        int n;
        n   = 0;
        idx = -1;
        while (m_grants == '0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (m_grants == '0) begin
            n_chk++;
            $display("FAIL grant_wait: no grant within 200 cycles at %0t", $time);
        end else begin
            for (int m = 0; m < NM; m++) if (m_grants[m]) idx = m;
        end
    endtask

    // Owner holds bus_util low for 'hold' sampled edges, then lets go;
    // returns in the RELEASE cycle.
    task automatic serve(input int hold, input bit drop);
        bus_util = 1'b0;
        repeat (hold) @(negedge clk);
        bus_util = 1'b1;
        if (drop) m_reqs = m_reqs & ~m_grants;
        @(negedge clk);
    endtask

    int got [6];
    int exp_order [6] = '{1, 3, 5, 1, 3, 5};
    int idx, n;

    initial begin
        #500000;
        $display("FAIL global_timeout: run did not complete");
        $fatal(1);
    end

    initial begin
        rstn = 1'b0; arb_mode = 1'b0; m_reqs = '0; bus_util = 1'b1; slaves_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_grants", int'(m_grants), 0);
        chk("rst_state",  int'(state), 0);
        chk("rst_mid",    int'(mid_current), 0);
        chk("rst_slvout", int'(slaves_out), 0);
        rstn = 1'b1;

        // Fixed priority: 3 beats 5, 5 follows after a RELEASE + IDLE gap.
        arb_mode = 1'b0; m_reqs = 12'h028;
        wait_grant(idx);
        chk("fx_first_grant", int'(m_grants), 12'h008);
        chk("fx_first_mid",   int'(mid_current), 3);
        serve(2, 1'b1);
        chk("fx_rel_state",  int'(state), 3);
        chk("fx_rel_grants", int'(m_grants), 0);
        @(negedge clk);
        chk("fx_idle_state", int'(state), 0);
        wait_grant(idx);
        chk("fx_second_grant", int'(m_grants), 12'h020);
        serve(1, 1'b1);

        // Round-robin among 1, 3, 5 with continuous requests.
        arb_mode = 1'b1; m_reqs = 12'h02A;
        for (int i = 0; i < 6; i++) begin
            wait_grant(idx);
            got[i] = idx;
            serve(4, 1'b0);
        end
        for (int i = 0; i < 6; i++) chk("rr_order", got[i], exp_order[i]);
        // Pointer wrap: 11 then pointer returns to 0.
        m_reqs = 12'h801;
        wait_grant(idx);
        chk("rr_wrap_hi", idx, 11);
        serve(1, 1'b0);
        wait_grant(idx);
        chk("rr_wrap_lo", idx, 0);
        serve(1, 1'b0);
        m_reqs = '0;

        // Watchdog: master 4 never takes the bus.
        arb_mode = 1'b0; m_reqs = 12'h010;
        wait_grant(idx);
        chk("wd_grant", idx, 4);
        n = 0;
        while (state == 4'd1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("wd_cycles",  n, GT);
        chk("wd_state",   int'(state), 3);
        chk("wd_evt",     int'(timeout_evt), 1);
        chk("wd_grants",  int'(m_grants), 0);
        m_reqs = '0;
        @(negedge clk);
        chk("wd_idle",    int'(state), 0);
        chk("wd_evt_off", int'(timeout_evt), 0);

        // Split: master 2 parked by slave 3, resumed ahead of master 1.
        m_reqs = 12'h004;
        wait_grant(idx);
        chk("sp_grant2", idx, 2);
        bus_util = 1'b0;
        @(negedge clk);
        slaves_in = 6'h08;
        @(negedge clk);
        bus_util = 1'b1; m_reqs = 12'h024;
        @(negedge clk);
        wait_grant(idx);
        chk("sp_masked", idx, 5);
        bus_util = 1'b0; m_reqs = 12'h026; slaves_in = '0;
        @(negedge clk);
        bus_util = 1'b1; m_reqs = 12'h006;
        @(negedge clk);
        wait_grant(idx);
        chk("sp_resume_mst", idx, 2);
        chk("sp_resume_so",  int'(slaves_out), 6'h08);
        bus_util = 1'b0;
        @(negedge clk);
        chk("sp_busy_so", int'(slaves_out), 6'h08);
        bus_util = 1'b1; m_reqs = 12'h002;
        @(negedge clk);
        chk("sp_rel_so", int'(slaves_out), 0);
        wait_grant(idx);
        chk("sp_then1", idx, 1);
        serve(1, 1'b1);

        // Reset in BUSY with a live split record.
        m_reqs = 12'h004;
        wait_grant(idx);
        bus_util = 1'b0;
        @(negedge clk);
        slaves_in = 6'h08;
        @(negedge clk);
        rstn = 1'b0; bus_util = 1'b1;
        @(negedge clk);
        chk("mr_grants", int'(m_grants), 0);
        chk("mr_state",  int'(state), 0);
        chk("mr_so",     int'(slaves_out), 0);
        chk("mr_mid",    int'(mid_current), 0);
        rstn = 1'b1;
        wait_grant(idx);
        chk("mr_unparked", idx, 2);
        serve(1, 1'b1);
        slaves_in = '0;

        // Mode change while BUSY only affects the next decision.
        arb_mode = 1'b0; m_reqs = 12'h041;
        wait_grant(idx);
        chk("md_fixed", idx, 0);
        bus_util = 1'b0; arb_mode = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("md_owner_kept", int'(m_grants), 12'h001);
        bus_util = 1'b1;
        @(negedge clk);
        wait_grant(idx);
        chk("md_rr_next", idx, 6);
        serve(1, 1'b1);
        m_reqs = '0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
